// File: rtl/keccak_pkg.sv
// Shared Keccak types and FIPS 202 lane/flat-order helpers for the loader, unpacker and permutation core.
package keccak_pkg;
  localparam int LANE_W  = 64;
  localparam int NLANES  = 25;
  localparam int STATE_W = 1600;

  typedef logic [LANE_W-1:0] lane_t;
  typedef lane_t [4:0][4:0] state_arr_t;  // indexed [x][y]

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2
  } ld_state_e;

  function automatic int lane_base(input int x, input int y);
    return LANE_W * (5 * y + x);
  endfunction

  function automatic logic [STATE_W-1:0] arr_to_flat(input state_arr_t a);
    logic [STATE_W-1:0] f;
    f = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        f[lane_base(x, y) +: LANE_W] = a[x][y];
    return f;
  endfunction

  function automatic state_arr_t flat_to_arr(input logic [STATE_W-1:0] f);
    state_arr_t a;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        a[x][y] = f[lane_base(x, y) +: LANE_W];
    return a;
  endfunction
endpackage

// File: rtl/keccak_lane_counter.sv
// Walks lane coordinates (x,y) in absorb order with mod-5 counting; idx tracks 5y+x without a divider.
module keccak_lane_counter #(
  parameter int RATE_LANES = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [2:0] x,
  output logic [2:0] y,
  output logic [4:0] idx,
  output logic       last
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x   <= '0;
      y   <= '0;
      idx <= '0;
    end else if (clr) begin
      x   <= '0;
      y   <= '0;
      idx <= '0;
    end else if (inc) begin
      if (x == 3'd4) begin
        x <= '0;
        y <= y + 3'd1;
      end else begin
        x <= x + 3'd1;
      end
      idx <= idx + 5'd1;
    end
  end

  assign last = (idx == 5'(RATE_LANES - 1));

endmodule

// File: rtl/keccak_state_loader.sv
// Streams 64-bit lanes into a 1600-bit Keccak state (overwrite or XOR-absorb) and hands it off valid/ready.
module keccak_state_loader #(
  parameter int RATE_LANES = 21,
  parameter int LANE_W     = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              xor_en,
  input  logic [1599:0]     prev_state,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LANE_W-1:0] in_data,
  input  logic              in_last,
  output logic [1599:0]     state_o,
  output logic              state_valid,
  input  logic              state_ready,
  output logic [4:0]        lanes_loaded
);
  import keccak_pkg::*;

  if (LANE_W != 64) begin : g_lane_w_chk
    $error("keccak_state_loader: LANE_W must be 64");
  end
  if (RATE_LANES < 1 || RATE_LANES > 25) begin : g_rate_chk
    $error("keccak_state_loader: RATE_LANES must be 1..25");
  end

  ld_state_e  st_q, st_d;
  logic       load, accept, xor_q;
  logic [2:0] cnt_x, cnt_y;
  logic       cnt_last;
  state_arr_t arr_q, arr_d, base_arr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st_q <= S_IDLE;
    else        st_q <= st_d;
  end

  always_comb begin
    st_d   = st_q;
    load   = 1'b0;
    accept = 1'b0;
    case (st_q)
      S_IDLE: if (start) begin
        st_d = S_LOAD;
        load = 1'b1;
      end
      S_LOAD: if (in_valid) begin
        accept = 1'b1;
        if (cnt_last || in_last) st_d = S_HOLD;
      end
      S_HOLD: if (state_ready) st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  assign in_ready    = (st_q == S_LOAD);
  assign state_valid = (st_q == S_HOLD);

  keccak_lane_counter #(.RATE_LANES(RATE_LANES)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (load),
    .inc   (accept),
    .x     (cnt_x),
    .y     (cnt_y),
    .idx   (lanes_loaded),
    .last  (cnt_last)
  );

  // The register is seeded with the base at start, and each lane is written
  // at most once per block, so XOR against the held lane equals XOR against base.
  assign base_arr = xor_en ? flat_to_arr(prev_state) : '0;

  for (genvar gx = 0; gx < 5; gx++) begin : g_x
    for (genvar gy = 0; gy < 5; gy++) begin : g_y
      logic hit;
      assign hit = accept && (cnt_x == 3'(gx)) && (cnt_y == 3'(gy));
      assign arr_d[gx][gy] = load ? base_arr[gx][gy]
                           : hit  ? (xor_q ? (arr_q[gx][gy] ^ in_data) : in_data)
                           : arr_q[gx][gy];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arr_q <= '0;
      xor_q <= 1'b0;
    end else begin
      arr_q <= arr_d;
      if (load) xor_q <= xor_en;
    end
  end

  assign state_o = arr_to_flat(arr_q);

endmodule

// File: tb/tb_keccak_state_loader.sv
// Directed bench for keccak_state_loader: lane-indexed reference model plus literal spot checks.
module tb_keccak_state_loader;
  localparam int RL = 21;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0, xor_en = 1'b0, in_valid = 1'b0, in_last = 1'b0, state_ready = 1'b0;
  logic [1599:0] prev_state = '0;
  logic [63:0]   in_data = '0;
  logic          in_ready, state_valid;
  logic [1599:0] state_o;
  logic [4:0]    lanes_loaded;

  int errors = 0;
  int checks = 0;
  logic run = 1'b0;

  // Reference: lane i lives at flat bits 64*i (5y+x == i)
  logic [63:0] m [25];
  int   mph = 0;   // 0 idle, 1 loading, 2 holding
  int   mcnt = 0;
  logic mxor = 1'b0;
  int   cbad;

  always #5 clk = ~clk;

  keccak_state_loader #(.RATE_LANES(RL), .LANE_W(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .xor_en       (xor_en),
    .prev_state   (prev_state),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .state_o      (state_o),
    .state_valid  (state_valid),
    .state_ready  (state_ready),
    .lanes_loaded (lanes_loaded)
  );

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 25; i++) m[i] <= '0;
      mph  <= 0;
      mcnt <= 0;
      mxor <= 1'b0;
    end else begin
      case (mph)
        0: if (start) begin
          for (int i = 0; i < 25; i++) m[i] <= xor_en ? prev_state[64*i +: 64] : 64'h0;
          mxor <= xor_en;
          mcnt <= 0;
          mph  <= 1;
        end
        1: if (in_valid) begin
          m[mcnt] <= mxor ? (m[mcnt] ^ in_data) : in_data;
          mcnt    <= mcnt + 1;
          if (mcnt + 1 == RL || in_last) mph <= 2;
        end
        2: if (state_ready) mph <= 0;
        default: mph <= 0;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_flat(input string nm, input logic [1599:0] exp);
    int b;
    b = -1;
    for (int i = 0; i < 25; i++) if (b < 0 && state_o[64*i +: 64] !== exp[64*i +: 64]) b = i;
    checks++;
    if (b >= 0) begin
      errors++;
      $display("FAIL %s lane %0d: got %h want %h", nm, b, state_o[64*b +: 64], exp[64*b +: 64]);
    end
  endtask

  always @(negedge clk) if (run) begin
    cbad = -1;
    for (int i = 0; i < 25; i++) if (cbad < 0 && state_o[64*i +: 64] !== m[i]) cbad = i;
    checks++;
    if (cbad >= 0) begin
      errors++;
      $display("FAIL model state_o lane %0d: got %h want %h", cbad, state_o[64*cbad +: 64], m[cbad]);
    end
    chk("model state_valid", 64'(state_valid), 64'(mph == 2));
    chk("model in_ready", 64'(in_ready), 64'(mph == 1));
    chk("model lanes_loaded", 64'(lanes_loaded), 64'(mcnt));
  end

  function automatic logic [63:0] lane(input int i);
    return state_o[64*i +: 64];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // prev_state and xor_en are scrambled after start to show they were captured
  task automatic start_blk(input logic xe, input logic [1599:0] p);
    start = 1'b1; xor_en = xe; prev_state = p;
    tick();
    start = 1'b0; xor_en = ~xe; prev_state = ~p;
  endtask

  task automatic send(input logic [63:0] d, input logic l);
    in_valid = 1'b1; in_data = d; in_last = l;
    tick();
    in_valid = 1'b0; in_last = 1'b0; in_data = {$urandom, $urandom};
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!state_valid && n < 40) begin tick(); n++; end
    checks++;
    if (!state_valid) begin
      errors++;
      $display("FAIL %s timeout: state_valid got 0 want 1", nm);
    end
  endtask

  task automatic release_hold();
    state_ready = 1'b1;
    tick();
    state_ready = 1'b0;
  endtask

  task automatic ramp_block(input string nm, input logic last_on_final);
    start_blk(1'b0, {25{64'hA5A5_5A5A_C3C3_3C3C}});
    for (int i = 0; i < RL; i++)
      send(64'h0101_0101_0101_0101 * 64'(i), last_on_final && (i == RL - 1));
    chk({nm, " valid latency"}, 64'(state_valid), 64'h1);
    chk({nm, " lane7"}, lane(7), 64'h0707_0707_0707_0707);
    chk({nm, " lane20"}, lane(20), 64'h1414_1414_1414_1414);
    chk({nm, " lane21 cap"}, lane(21), 64'h0);
    chk({nm, " lane24 cap"}, lane(24), 64'h0);
    chk({nm, " in_ready"}, 64'(in_ready), 64'h0);
    chk({nm, " count"}, 64'(lanes_loaded), 64'd21);
    release_hold();
    chk({nm, " idle after ready"}, 64'(state_valid), 64'h0);
  endtask

  initial begin
    logic [1599:0] e;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    run = 1'b1;
    chk_flat("reset state_o", '0);
    chk("reset state_valid", 64'(state_valid), 64'h0);
    chk("reset in_ready", 64'(in_ready), 64'h0);
    chk("reset lanes_loaded", 64'(lanes_loaded), 64'h0);

    // Overwrite ramp
    ramp_block("t1", 1'b0);

    // XOR absorb, state_ready asserted early while not holding
    start_blk(1'b1, '1);
    state_ready = 1'b1;
    for (int i = 0; i < RL; i++) begin
      if (i == 5) state_ready = 1'b0;
      send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    end
    wait_valid("t2");
    chk("t2 lane0", lane(0), 64'h0);
    chk("t2 lane20", lane(20), 64'h0);
    chk("t2 lane21", lane(21), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t2 lane24", lane(24), 64'hFFFF_FFFF_FFFF_FFFF);
    release_hold();

    // Short block; start mid-load must be ignored
    start_blk(1'b0, {25{64'h1234_5678_9ABC_DEF0}});
    send(64'h11, 1'b0);
    start = 1'b1;
    send(64'h22, 1'b0);
    start = 1'b0;
    send(64'h33, 1'b1);
    chk("t3 lanes_loaded", 64'(lanes_loaded), 64'd3);
    chk("t3 in_ready", 64'(in_ready), 64'h0);
    chk("t3 lane2", lane(2), 64'h33);
    chk("t3 lane3", lane(3), 64'h0);

    // Backpressure: words and start while holding are ignored
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; in_data = {$urandom, $urandom}; start = 1'b1;
      tick();
    end
    chk("t4 valid held", 64'(state_valid), 64'h1);
    chk("t4 lane0 stable", lane(0), 64'h11);
    chk("t4 count stable", 64'(lanes_loaded), 64'd3);
    state_ready = 1'b1;
    tick();
    state_ready = 1'b0; start = 1'b0; in_valid = 1'b0;
    chk("t4 start on exit ignored", 64'(in_ready), 64'h0);
    tick();
    chk("t4 still idle", 64'(in_ready), 64'h0);

    // One-lane block in XOR mode
    start_blk(1'b1, {25{64'h0123_4567_89AB_CDEF}});
    send(64'hFF, 1'b1);
    chk("t1lane valid", 64'(state_valid), 64'h1);
    chk("t1lane lane0", lane(0), 64'h0123_4567_89AB_CD10);
    chk("t1lane lane1", lane(1), 64'h0123_4567_89AB_CDEF);
    chk("t1lane count", 64'(lanes_loaded), 64'd1);
    release_hold();

    // Bit mapping: lane 6 = (x=1,y=1) -> flat bit 384
    start_blk(1'b0, '1);
    for (int i = 0; i < 6; i++) send(64'h0, 1'b0);
    send(64'h1, 1'b1);
    e = '0;
    e[384] = 1'b1;
    chk_flat("t5 bit384", e);
    release_hold();

    // Reset during load, then a clean block ending with in_last on the final lane
    start_blk(1'b0, '0);
    for (int i = 0; i < 5; i++) send(64'hDEAD_BEEF_0000_0000 | 64'(i), 1'b0);
    #2 reset = 1'b0;
    #1;
    chk_flat("t6 reset state_o", '0);
    chk("t6 reset state_valid", 64'(state_valid), 64'h0);
    chk("t6 reset in_ready", 64'(in_ready), 64'h0);
    chk("t6 reset lanes_loaded", 64'(lanes_loaded), 64'h0);
    @(posedge clk);
    #3 reset = 1'b1;
    tick();
    ramp_block("t6", 1'b1);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
